i2c_slave: RTL and testbench
============================

I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter ADDR, default 7'h42: the 7-bit target address this block responds to.
REQ-002 SHALL have port clk, input, 1: 50 MHz system clock. One clock; all logic on posedge clk.
REQ-003 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port scl, input, 1: I2C clock from the master. No clock stretching.
REQ-005 SHALL have port sda, inout, 1: I2C data, open-drain (drives 1'b0 or 1'bz, never 1'b1).
REQ-006 SHALL have port rx_data, output, 8: last byte received from the master in a write.
REQ-007 SHALL have port rx_valid, output, 1: one-cycle pulse; rx_data is new.
REQ-008 SHALL have port tx_data, input, 8: byte to return to the master in a read.
REQ-009 SHALL have port tx_req, output, 1: one-cycle pulse; tx_data is about to be latched.
REQ-010 SHALL have port busy, output, 1: high while addressed, from address ACK until STOP, repeated START, or read NACK.

Function
REQ-011 SHALL pass scl and sda through 2-flop synchronizers; all edge and START/STOP detection SHALL use the synchronized values and their previous-cycle copies.
REQ-012 SHALL detect START as synced sda 1->0 while synced scl is high, and STOP as synced sda 1->0... corrected: STOP is synced sda 0->1 while synced scl is high.
REQ-013 SHALL implement states IDLE, ADDR, ADDR_ACK, WR, WR_ACK, RD, RD_ACK.
REQ-014 SHALL sample sda on each synced scl rising edge, MSB first, and count bits 0..7 with a 3-bit counter that wraps to 0 after each byte.
REQ-015 SHALL change its own sda drive only on synced scl falling edges.
REQ-016 SHALL, from IDLE, enter ADDR on START.
REQ-017 SHALL, in ADDR after 8 bits, compare bits[7:1] with ADDR: on mismatch go to IDLE with sda released; on match go to ADDR_ACK and latch bit0 as R/W.
REQ-018 SHALL, in ADDR_ACK, pull sda low from the next scl falling edge to the following falling edge and assert busy; R/W=0 then goes to WR, R/W=1 goes to RD.
REQ-019 SHALL, on an address match with R/W=1, pulse tx_req on the cycle the 8th address bit is sampled.
REQ-020 SHALL, in WR after 8 bits, load rx_data and pulse rx_valid on the cycle the 8th rising edge is sampled, then ACK in WR_ACK (sda low for one scl period) and return to WR.
REQ-021 SHALL always ACK written bytes; there is no backpressure. A byte not consumed before the next rx_valid is overwritten.
REQ-022 SHALL, in RD, latch tx_data into a shift register on the scl falling edge that starts bit 7, then drive each bit on successive falling edges (0 -> low, 1 -> release).
REQ-023 SHALL release sda on the falling edge after bit 0 and sample the master's ACK bit on the 9th rising edge (RD_ACK).
REQ-024 SHALL, when the master ACKs (sda=0), pulse tx_req on that same cycle and return to RD.
REQ-025 SHALL, when the master NACKs (sda=1), go to IDLE, release sda, and deassert busy.
REQ-026 SHALL require tx_data to be stable from tx_req+1 cycle until the latching scl falling edge (at least half an scl period later).
REQ-027 SHALL, on STOP in any state, go to IDLE, release sda, deassert busy, and discard any partial byte (no rx_valid).
REQ-028 SHALL, on START in any state (repeated START), go to ADDR with the bit counter cleared, sda released, and busy deasserted.
REQ-029 SHALL give START/STOP detection priority over a bit sample when both occur in the same cycle.
REQ-030 SHALL have a latency of scl/sda pin to internal edge detection of 3 clk cycles; this is supported for scl at up to 400 kHz.

Reset
REQ-031 SHALL, while rst is high at a posedge clk, set: state=IDLE, sda released (1'bz), rx_data=8'h00, rx_valid=0, tx_req=0, busy=0, bit counter=0, shift registers=0, synchronizers=1.
REQ-032 SHALL treat rst asserted mid-transfer as an abort: release sda immediately on the next edge and ignore the bus until the next START.

Verification
REQ-033 SHALL be verified for a write: START, 0x84 (0x42,W), 0xA5, STOP -> ACKs at both 9th clocks, rx_data=0xA5, one rx_valid pulse, busy 1 then 0 after STOP.
REQ-034 SHALL be verified for a wrong address: START, 0x86, 0x11 -> sda never driven low, no rx_valid, no tx_req, busy=0 throughout.
REQ-035 SHALL be verified for a read: START, 0x85, tx_data=0x3C, master ACK, then tx_data=0xC3, master NACK -> sda bits 0x3C then 0xC3, tx_req pulsed twice, IDLE after the NACK.
REQ-036 SHALL be verified for a repeated START: START, 0x84, 0x01, rSTART, 0x85, read 1 byte -> rx_data=0x01 with one rx_valid, then the read proceeds normally.
REQ-037 SHALL be verified for STOP mid-byte: START, 0x84, 4 bits of data, STOP -> no rx_valid, sda released, busy=0.
REQ-038 SHALL be verified for reset mid-ACK: rst high for 1 cycle while sda is pulled low in ADDR_ACK -> sda=z next cycle, all outputs at reset values, the next START is handled normally.

Source files
------------

// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address, byte-wide write and read, and an open-drain sda.
// No clock stretching: every bus event is taken from synchronized scl/sda edges.
module i2c_slave #(
  parameter logic [6:0] ADDR = 7'h42
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       busy
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_WR,
    S_WR_ACK,
    S_RD,
    S_RD_ACK
  } state_t;

  logic scl_meta, scl_sync, scl_prev;
  logic sda_meta, sda_sync, sda_prev;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-2:0]  shift_q, shift_d;
  logic [BYTE_W-2:0]  tx_shift_q, tx_shift_d;
  logic               rw_q, rw_d;
  logic               ack_drv_q, ack_drv_d;
  logic               sda_low_q, sda_low_d;
  logic [BYTE_W-1:0]  rx_data_d;
  logic               rx_valid_d, tx_req_d, busy_d;

  logic               scl_rise, scl_fall, start_det, stop_det;
  logic [BYTE_W-1:0]  rx_byte;

  assign sda = sda_low_q ? 1'b0 : 1'bz;

  assign scl_rise  = scl_sync & ~scl_prev;
  assign scl_fall  = ~scl_sync & scl_prev;
  assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;
  assign rx_byte   = {shift_q, sda_sync};

  // Two-flop synchronizers plus a previous-cycle copy for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_meta <= 1'b1;
      scl_sync <= 1'b1;
      scl_prev <= 1'b1;
      sda_meta <= 1'b1;
      sda_sync <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_meta <= scl;
      scl_sync <= scl_meta;
      scl_prev <= scl_sync;
      sda_meta <= sda;
      sda_sync <= sda_meta;
      sda_prev <= sda_sync;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_shift_q <= '0;
      rw_q       <= 1'b0;
      ack_drv_q  <= 1'b0;
      sda_low_q  <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_req     <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_shift_q <= tx_shift_d;
      rw_q       <= rw_d;
      ack_drv_q  <= ack_drv_d;
      sda_low_q  <= sda_low_d;
      rx_data    <= rx_data_d;
      rx_valid   <= rx_valid_d;
      tx_req     <= tx_req_d;
      busy       <= busy_d;
    end
  end

  // Bus framing wins over bit sampling; ACK states use ack_drv to span two scl falls.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    tx_shift_d = tx_shift_q;
    rw_d       = rw_q;
    ack_drv_d  = ack_drv_q;
    sda_low_d  = sda_low_q;
    rx_data_d  = rx_data;
    rx_valid_d = 1'b0;
    tx_req_d   = 1'b0;
    busy_d     = busy;

    if (start_det || stop_det) begin
      state_d   = start_det ? S_ADDR : S_IDLE;
      bit_cnt_d = '0;
      ack_drv_d = 1'b0;
      sda_low_d = 1'b0;
      busy_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;

        S_ADDR: begin
          if (scl_rise) begin
            shift_d   = rx_byte[BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              if (rx_byte[7:1] == ADDR) begin
                state_d   = S_ADDR_ACK;
                rw_d      = rx_byte[0];
                tx_req_d  = rx_byte[0];
                busy_d    = 1'b1;
                ack_drv_d = 1'b0;
              end else begin
                state_d   = S_IDLE;
              end
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_low_d = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              ack_drv_d = 1'b0;
              if (rw_q) begin
                state_d    = S_RD;
                tx_shift_d = tx_data[BYTE_W-2:0];
                sda_low_d  = ~tx_data[BYTE_W-1];
              end else begin
                state_d    = S_WR;
                sda_low_d  = 1'b0;
              end
            end
          end
        end

        S_WR: begin
          if (scl_rise) begin
            shift_d   = rx_byte[BYTE_W-2:0];
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              rx_data_d  = rx_byte;
              rx_valid_d = 1'b1;
              state_d    = S_WR_ACK;
              ack_drv_d  = 1'b0;
            end
          end
        end

        S_WR_ACK: begin
          if (scl_fall) begin
            if (!ack_drv_q) begin
              sda_low_d = 1'b1;
              ack_drv_d = 1'b1;
            end else begin
              sda_low_d = 1'b0;
              ack_drv_d = 1'b0;
              state_d   = S_WR;
            end
          end
        end

        S_RD: begin
          if (scl_rise) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(7)) begin
              state_d = S_RD_ACK;
            end
          end else if (scl_fall) begin
            // A fall with the counter at 0 opens a new byte after a master ACK.
            if (bit_cnt_q == CNT_W'(0)) begin
              tx_shift_d = tx_data[BYTE_W-2:0];
              sda_low_d  = ~tx_data[BYTE_W-1];
            end else begin
              tx_shift_d = {tx_shift_q[BYTE_W-3:0], 1'b0};
              sda_low_d  = ~tx_shift_q[BYTE_W-2];
            end
          end
        end

        S_RD_ACK: begin
          if (scl_fall) begin
            sda_low_d = 1'b0;
          end else if (scl_rise) begin
            if (!sda_sync) begin
              tx_req_d = 1'b1;
              state_d  = S_RD;
            end else begin
              state_d   = S_IDLE;
              sda_low_d = 1'b0;
              busy_d    = 1'b0;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level I2C master drives directed scenarios and randomized
// transfers; expectations come from a transaction-level model of address match and data flow.
module tb_i2c_slave;

  localparam int unsigned Q   = 32;
  localparam logic [6:0]  DEV = 7'h42;

  logic       clk = 1'b0;
  logic       rst;
  logic       scl;
  logic       m_low;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       rx_valid, tx_req, busy;
  wire        sda;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  i2c_slave #(.ADDR(DEV)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl      (scl),
    .sda      (sda),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_req   (tx_req),
    .busy     (busy)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int rxv_cnt = 0, txr_cnt = 0, dut_low_cnt = 0, busy_cnt = 0;

  // Event counters sampled mid-cycle; sda low while the master releases means the target drives it.
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxv_cnt++;
    if (tx_req === 1'b1) txr_cnt++;
    if (busy === 1'b1) busy_cnt++;
    if (sda === 1'b0 && m_low === 1'b0) dut_low_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clock_bit(input logic b, output logic seen);
    m_low = ~b;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    seen = sda;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic bus_start();
    m_low = 1'b0;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    m_low = 1'b1;
    tick(Q);
    scl = 1'b0;
    tick(Q);
  endtask

  task automatic bus_stop();
    m_low = 1'b1;
    tick(Q);
    scl = 1'b1;
    tick(Q);
    m_low = 1'b0;
    tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic seen;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], seen);
    clock_bit(1'b1, seen);
    ack = ~seen;
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack, input logic [7:0] next_tx);
    logic seen;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, seen);
      b[i] = seen;
    end
    tx_data = next_tx;
    clock_bit(~mack, seen);
  endtask

  initial begin
    logic       ack, seen, rw, match;
    logic [7:0] rb, wb, exp_rx;
    logic [6:0] a7;
    logic [7:0] txq [3];
    int         s_rxv, s_txr, s_low, s_busy, n;

    rst = 1'b1; scl = 1'b1; m_low = 1'b0; tx_data = 8'h00;
    exp_rx = 8'h00;
    tick(5);
    rst = 1'b0;
    tick(4);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_tx_req", tx_req, 0);
    check("rst_busy", busy, 0);
    check("rst_sda", sda, 1);

    // Write 0xA5 to our address
    s_rxv = rxv_cnt;
    bus_start();
    send_byte(8'h84, ack);
    check("wr_addr_ack", ack, 1);
    check("wr_busy", busy, 1);
    send_byte(8'hA5, ack);
    check("wr_data_ack", ack, 1);
    bus_stop();
    tick(8);
    exp_rx = 8'hA5;
    check("wr_rx_data", rx_data, exp_rx);
    check("wr_rx_valid_cnt", rxv_cnt - s_rxv, 1);
    check("wr_busy_after_stop", busy, 0);
    check("wr_sda_released", sda, 1);

    // Wrong address: target stays silent
    s_rxv = rxv_cnt; s_txr = txr_cnt; s_low = dut_low_cnt; s_busy = busy_cnt;
    bus_start();
    send_byte(8'h86, ack);
    check("wa_addr_nack", ack, 0);
    send_byte(8'h11, ack);
    check("wa_data_nack", ack, 0);
    bus_stop();
    tick(8);
    check("wa_sda_never_low", dut_low_cnt - s_low, 0);
    check("wa_no_rx_valid", rxv_cnt - s_rxv, 0);
    check("wa_no_tx_req", txr_cnt - s_txr, 0);
    check("wa_busy_never", busy_cnt - s_busy, 0);
    check("wa_rx_data_kept", rx_data, exp_rx);

    // Read two bytes: ACK after the first, NACK after the second
    tx_data = 8'h3C;
    s_txr = txr_cnt;
    bus_start();
    send_byte(8'h85, ack);
    check("rd_addr_ack", ack, 1);
    recv_byte(rb, 1'b1, 8'hC3);
    check("rd_byte0", rb, 8'h3C);
    recv_byte(rb, 1'b0, 8'h00);
    check("rd_byte1", rb, 8'hC3);
    check("rd_busy_after_nack", busy, 0);
    check("rd_tx_req_cnt", txr_cnt - s_txr, 2);
    bus_stop();
    tick(8);

    // Write then repeated START into a read
    s_rxv = rxv_cnt; s_txr = txr_cnt;
    bus_start();
    send_byte(8'h84, ack);
    check("rs_wr_addr_ack", ack, 1);
    send_byte(8'h01, ack);
    check("rs_wr_data_ack", ack, 1);
    bus_start();
    check("rs_busy_cleared", busy, 0);
    tx_data = 8'h5A;
    send_byte(8'h85, ack);
    check("rs_rd_addr_ack", ack, 1);
    recv_byte(rb, 1'b0, 8'h00);
    check("rs_rd_byte", rb, 8'h5A);
    bus_stop();
    tick(8);
    exp_rx = 8'h01;
    check("rs_rx_data", rx_data, exp_rx);
    check("rs_rx_valid_cnt", rxv_cnt - s_rxv, 1);
    check("rs_tx_req_cnt", txr_cnt - s_txr, 1);

    // STOP in the middle of a written byte
    s_rxv = rxv_cnt;
    bus_start();
    send_byte(8'h84, ack);
    check("sm_addr_ack", ack, 1);
    clock_bit(1'b1, seen);
    clock_bit(1'b0, seen);
    clock_bit(1'b1, seen);
    clock_bit(1'b0, seen);
    bus_stop();
    tick(8);
    check("sm_no_rx_valid", rxv_cnt - s_rxv, 0);
    check("sm_busy", busy, 0);
    check("sm_sda_released", sda, 1);
    check("sm_rx_data_kept", rx_data, exp_rx);

    // Reset while the address ACK is being driven
    wb = 8'h84;
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(wb[i], seen);
    m_low = 1'b0;
    tick(1);
    check("ra_ack_driven", sda, 0);
    check("ra_busy_before", busy, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("ra_sda_released", sda, 1);
    check("ra_busy", busy, 0);
    check("ra_rx_data", rx_data, 0);
    check("ra_rx_valid", rx_valid, 0);
    check("ra_tx_req", tx_req, 0);
    exp_rx = 8'h00;
    clock_bit(1'b1, seen);
    check("ra_ack_slot_released", seen, 1);
    bus_stop();
    tick(8);
    bus_start();
    send_byte(8'h84, ack);
    check("ra_next_addr_ack", ack, 1);
    send_byte(8'h7E, ack);
    check("ra_next_data_ack", ack, 1);
    bus_stop();
    tick(8);
    exp_rx = 8'h7E;
    check("ra_next_rx_data", rx_data, exp_rx);

    // Randomized transfers against the transaction model
    for (int t = 0; t < 5; t++) begin
      a7    = ($urandom_range(0, 1) == 1) ? DEV : 7'($urandom_range(0, 127));
      rw    = 1'($urandom_range(0, 1));
      n     = int'($urandom_range(1, 3));
      match = (a7 == DEV);
      for (int k = 0; k < 3; k++) txq[k] = 8'($urandom);
      s_rxv = rxv_cnt; s_txr = txr_cnt;
      tx_data = txq[0];
      bus_start();
      send_byte({a7, rw}, ack);
      check("rnd_addr_ack", ack, match);
      for (int k = 0; k < n; k++) begin
        if (!rw) begin
          wb = 8'($urandom);
          send_byte(wb, ack);
          check("rnd_wr_ack", ack, match);
          if (match) exp_rx = wb;
        end else begin
          recv_byte(rb, k < n - 1, (k < n - 1) ? txq[k + 1] : 8'h00);
          check("rnd_rd_byte", rb, match ? txq[k] : 8'hFF);
        end
      end
      bus_stop();
      tick(8);
      check("rnd_rx_data", rx_data, exp_rx);
      check("rnd_rx_valid_cnt", rxv_cnt - s_rxv, (!rw && match) ? n : 0);
      check("rnd_tx_req_cnt", txr_cnt - s_txr, (rw && match) ? n : 0);
      check("rnd_busy", busy, 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
